// File: rtl/uranus_pkg.sv
// Shared airlock types: state encoding, counter width and 7-segment letters.
package uranus_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned CountW = 4;
    localparam int unsigned DispW  = 7;

    typedef enum logic [StateW-1:0] {
        IDLE       = 3'd0,
        DEPART_T   = 3'd1,
        WAIT_PRESS = 3'd2,
        PRESS_T    = 3'd3,
        WAIT_EVAC  = 3'd4,
        EVAC_T     = 3'd5,
        WAIT_LEAVE = 3'd6
    } uranusState_e;

    // Active-low segments, bit order gfedcba
    localparam logic [DispW-1:0] dispBlank = 7'b1111111;
    localparam logic [DispW-1:0] dispD     = 7'b0100001;
    localparam logic [DispW-1:0] dispP     = 7'b0001100;
    localparam logic [DispW-1:0] dispE     = 7'b0000110;

endpackage

// File: rtl/second_timer.sv
// Counts one-second ticks inside a timing state; clear wins over counting.
module second_timer
    import uranus_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              hold,
    input  logic              tick,
    output logic [CountW-1:0] count
);

    // Clear on state entry/reset, otherwise advance on unheld ticks
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (tick && !hold) begin
            count <= count + CountW'(1);
        end
    end

endmodule

// File: rtl/leaving_uranus.sv
// Airlock sequencer for a ship departing the station: depart, pressurize, evacuate, leave.
module leaving_uranus
    import uranus_pkg::*;
#(
    parameter int unsigned DEPART_SEC = 5,
    parameter int unsigned PRESS_SEC  = 8,
    parameter int unsigned EVAC_SEC   = 7
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             tick,
    input  logic             departing,
    input  logic             pressurize,
    input  logic             evac,
    input  logic             innerPort,
    input  logic             outerPort,
    output logic             canIn,
    output logic             canOut,
    output logic [DispW-1:0] display,
    output logic             busy
);

    // Count value reached just before the final tick of each timing state
    localparam logic [CountW-1:0] departLast = CountW'(DEPART_SEC - 1);
    localparam logic [CountW-1:0] pressLast  = CountW'(PRESS_SEC - 1);
    localparam logic [CountW-1:0] evacLast   = CountW'(EVAC_SEC - 1);

    uranusState_e      state;
    uranusState_e      stateNext;
    logic [CountW-1:0] count;
    logic              timingHold;
    logic              tickLive;
    logic              timerClear;
    logic              portsClosed;

    assign portsClosed = !innerPort && !outerPort;
    // An open door freezes pressurize/evacuate timing until both close
    assign timingHold  = ((state == PRESS_T) || (state == EVAC_T)) && !portsClosed;
    assign tickLive    = tick && !timingHold;
    // Every state change restarts the count, so an entry-edge tick is dropped
    assign timerClear  = rst || (stateNext != state);

    second_timer uTimer (
        .clock (clock),
        .clear (timerClear),
        .hold  (timingHold),
        .tick  (tick),
        .count (count)
    );

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        stateNext = state;
        canIn     = 1'b0;
        canOut    = 1'b0;
        display   = dispBlank;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (departing) stateNext = DEPART_T;
            end
            DEPART_T: begin
                display = dispD;
                if (tickLive && (count == departLast)) stateNext = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (pressurize && portsClosed) stateNext = PRESS_T;
            end
            PRESS_T: begin
                display = dispP;
                if (tickLive && (count == pressLast)) stateNext = WAIT_EVAC;
            end
            WAIT_EVAC: begin
                canIn = 1'b1;
                if (evac && portsClosed) stateNext = EVAC_T;
            end
            EVAC_T: begin
                display = dispE;
                if (tickLive && (count == evacLast)) stateNext = WAIT_LEAVE;
            end
            WAIT_LEAVE: begin
                canOut = 1'b1;
                if (!departing) stateNext = IDLE;
            end
            default: begin
                busy      = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_leaving_uranus.sv
// Directed bench for the airlock sequencer, default timing parameters.
module tb_leaving_uranus;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       departing = 1'b0;
    logic       pressurize = 1'b0;
    logic       evac = 1'b0;
    logic       innerPort = 1'b0;
    logic       outerPort = 1'b0;
    logic       canIn;
    logic       canOut;
    logic [6:0] display;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    localparam logic [6:0] blankL = 7'b1111111;
    localparam logic [6:0] dL     = 7'b0100001;
    localparam logic [6:0] pL     = 7'b0001100;
    localparam logic [6:0] eL     = 7'b0000110;

    leaving_uranus dut (
        .clock      (clock),
        .rst        (rst),
        .tick       (tick),
        .departing  (departing),
        .pressurize (pressurize),
        .evac       (evac),
        .innerPort  (innerPort),
        .outerPort  (outerPort),
        .canIn      (canIn),
        .canOut     (canOut),
        .display    (display),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One tick pulse followed by nine quiet cycles
    task automatic pulseTick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(9);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulseTick();
    endtask

    task automatic chkOut(input string tag, input logic [6:0] d, input logic b,
                          input logic ci, input logic co);
        chk({tag, ".display"}, display, d);
        chk({tag, ".busy"}, 7'(busy), 7'(b));
        chk({tag, ".canIn"}, 7'(canIn), 7'(ci));
        chk({tag, ".canOut"}, 7'(canOut), 7'(co));
    endtask

    initial begin
        cyc(3);
        chkOut("reset", blankL, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2);
        chkOut("idle", blankL, 1'b0, 1'b0, 1'b0);

        // Depart entry with a coincident tick that must not count
        departing = 1'b1;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chkOut("departEntry", dL, 1'b1, 1'b0, 1'b0);
        departing = 1'b0;
        cyc(2);
        chk("departNoAbort", display, dL);
        ticks(4);
        chkOut("depart5thIssued", dL, 1'b1, 1'b0, 1'b0);
        pulseTick();
        chkOut("waitPress", blankL, 1'b1, 1'b0, 1'b0);

        // Pressurize blocked by open inner door; evac ignored here
        innerPort = 1'b1;
        pressurize = 1'b1;
        cyc(2);
        pressurize = 1'b0;
        cyc(1);
        chk("pressBlocked", display, blankL);
        innerPort = 1'b0;
        evac = 1'b1;
        cyc(2);
        evac = 1'b0;
        chk("evacWrongState", display, blankL);

        // Pressurize with a four-tick door-open hold
        pressurize = 1'b1;
        cyc(1);
        pressurize = 1'b0;
        chkOut("pressEntry", pL, 1'b1, 1'b0, 1'b0);
        ticks(3);
        outerPort = 1'b1;
        ticks(4);
        chk("pressHeld", display, pL);
        outerPort = 1'b0;
        ticks(4);
        chk("press11Issued", display, pL);
        pulseTick();
        chkOut("waitEvac", blankL, 1'b1, 1'b1, 1'b0);

        // Both buttons together: only evac advances
        pressurize = 1'b1;
        evac = 1'b1;
        cyc(1);
        pressurize = 1'b0;
        evac = 1'b0;
        chkOut("evacEntry", eL, 1'b1, 1'b0, 1'b0);
        ticks(4);
        chk("evac4", display, eL);

        // Reset mid-evacuate discards everything
        rst = 1'b1;
        cyc(1);
        chkOut("midReset", blankL, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2);
        chk("postResetIdle", 7'(busy), 7'(1'b0));

        // Second run straight through to a full evacuate
        departing = 1'b1;
        cyc(1);
        chk("run2Depart", display, dL);
        ticks(5);
        chk("run2WaitPress", display, blankL);
        pressurize = 1'b1;
        cyc(1);
        pressurize = 1'b0;
        ticks(8);
        chk("run2WaitEvac", 7'(canIn), 7'(1'b1));
        evac = 1'b1;
        cyc(1);
        evac = 1'b0;
        ticks(6);
        chk("run2Evac6", display, eL);
        pulseTick();
        chkOut("waitLeave", blankL, 1'b1, 1'b0, 1'b1);
        cyc(5);
        chk("waitLeaveHold", 7'(canOut), 7'(1'b1));
        departing = 1'b0;
        cyc(1);
        chkOut("leftIdle", blankL, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
